// File: rtl/alarm_annunciator.sv
`default_nettype none
// ============================================================================
// Module      : alarm_annunciator
// Description : Latched, armable alarm with trigger debounce, entry delay,
//               cadenced siren, acknowledge path and saturating event count.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_annunciator #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ENTRY_DELAY     = 16,
    parameter int SIREN_HALF      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       arm,
    input  logic       trigger,
    input  logic       ack,
    output logic       armed,
    output logic       pending,
    output logic       alarm_active,
    output logic       siren,
    output logic [7:0] event_count
);

    localparam int c_DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_DLY_W = (ENTRY_DELAY > 1) ? $clog2(ENTRY_DELAY) : 1;
    localparam int c_SIR_W = (SIREN_HALF > 1) ? $clog2(SIREN_HALF) : 1;

    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DLY_W-1:0] c_DLY_LOAD = c_DLY_W'(ENTRY_DELAY - 1);
    localparam logic [c_SIR_W-1:0] c_SIR_LOAD = c_SIR_W'(SIREN_HALF - 1);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_ENTRY    = 2'd2,
        ST_ALARM    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_DEB_W-1:0]   r_deb_cnt;
    logic [c_DEB_W-1:0]   w_deb_nxt;
    logic [c_DLY_W-1:0]   r_dly_cnt;
    logic [c_DLY_W-1:0]   w_dly_nxt;
    logic [c_SIR_W-1:0]   r_sir_cnt;
    logic [c_SIR_W-1:0]   w_sir_nxt;
    logic                 r_siren;
    logic                 w_siren_nxt;
    logic [7:0]           r_event_count;
    logic [7:0]           w_evt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_DISARMED;
            r_deb_cnt     <= '0;
            r_dly_cnt     <= '0;
            r_sir_cnt     <= '0;
            r_siren       <= 1'b0;
            r_event_count <= 8'd0;
        end else if (ena) begin
            r_state       <= w_state_nxt;
            r_deb_cnt     <= w_deb_nxt;
            r_dly_cnt     <= w_dly_nxt;
            r_sir_cnt     <= w_sir_nxt;
            r_siren       <= w_siren_nxt;
            r_event_count <= w_evt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_deb_nxt   = r_deb_cnt;
        w_dly_nxt   = r_dly_cnt;
        w_sir_nxt   = r_sir_cnt;
        w_siren_nxt = r_siren;
        w_evt_nxt   = r_event_count;

        // Disarm overrides everything, including a same-cycle ENTRY->ALARM edge
        if (!arm) begin
            w_state_nxt = ST_DISARMED;
            w_deb_nxt   = '0;
            w_dly_nxt   = '0;
            w_siren_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_DISARMED: begin
                    w_state_nxt = ST_ARMED;
                    w_deb_nxt   = '0;
                end
                ST_ARMED: begin
                    if (trigger) begin
                        if (r_deb_cnt == c_DEB_LAST) begin
                            w_state_nxt = ST_ENTRY;
                            w_dly_nxt   = c_DLY_LOAD;
                            w_deb_nxt   = '0;
                        end else begin
                            w_deb_nxt = r_deb_cnt + 1'b1;
                        end
                    end else begin
                        w_deb_nxt = '0;
                    end
                end
                ST_ENTRY: begin
                    if (r_dly_cnt == '0) begin
                        w_state_nxt = ST_ALARM;
                        w_sir_nxt   = c_SIR_LOAD;
                        w_siren_nxt = 1'b1;
                        if (r_event_count != 8'hFF) begin
                            w_evt_nxt = r_event_count + 8'd1;
                        end
                    end else begin
                        w_dly_nxt = r_dly_cnt - 1'b1;
                    end
                end
                ST_ALARM: begin
                    // A retained trigger must re-debounce from zero after ack
                    if (ack) begin
                        w_state_nxt = ST_ARMED;
                        w_deb_nxt   = '0;
                        w_siren_nxt = 1'b0;
                    end else if (r_sir_cnt == '0) begin
                        w_sir_nxt   = c_SIR_LOAD;
                        w_siren_nxt = ~r_siren;
                    end else begin
                        w_sir_nxt = r_sir_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_DISARMED;
                end
            endcase
        end
    end

    assign armed        = (r_state != ST_DISARMED);
    assign pending      = (r_state == ST_ENTRY);
    assign alarm_active = (r_state == ST_ALARM);
    assign siren        = r_siren;
    assign event_count  = r_event_count;

endmodule
`default_nettype wire
